banco_registros_bus: RTL
========================

# banco_registros_bus

Parametrised register bank with a shared tri-state read bus. It is the multi-register, multi-mode successor of the single 4-bit D register with output buffer. DEPTH words of WIDTH bits each support per-word load, serial shift left/right and clear, and a registered read port drives a shared bus through a tri-state buffer. It sits between datapath producers and a shared multi-driver bus where several banks take turns driving Q.

## Interface
- WIDTH, 4, bits per word (≥2)
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- EN  in  1  write/operate enable for word at WADDR
- WADDR  in  ADDR_W  target word for the MODE operation
- MODE  in  2  00 load D, 01 shift left, 10 shift right, 11 clear
- D  in  WIDTH  parallel load data
- SIN  in  1  serial input bit for shifts
- SOUT  out  1  registered bit shifted out by the last shift operation
- OE  in  1  read request / bus drive enable
- RADDR  in  ADDR_W  word to read
- Q  out  WIDTH  tri-state bus: read data when driving, all-Z otherwise
- RD_VALID  out  1  high while Q is driven with a word written since reset/clear

## Operation
- Storage: DEPTH×WIDTH words plus one valid flag per word.
- On a rising edge with EN=1, the word at WADDR updates per MODE:
  - 00: word←D, valid←1.
  - 01: word←{word[WIDTH-2:0],SIN}, SOUT←word[WIDTH-1], valid←1.
  - 10: word←{SIN,word[WIDTH-1:1]}, SOUT←word[0], valid←1.
  - 11: word←0, valid←0; SOUT unchanged.
- EN=0: all words, flags and SOUT hold. SOUT changes only on shift operations.
- Read pipeline, one register stage:
  - On each rising edge: oe_q←OE.
  - If OE=1: rd_q←word[RADDR] and rv_q←valid[RADDR]. If OE=0: rd_q and rv_q hold.
- Output: Q = oe_q ? rd_q : all-Z; RD_VALID = oe_q & rv_q. RD_VALID is never X and is 0 whenever Q is Z.
- Read-during-write to the same address in the same edge returns the pre-write (old) word and old valid flag. There is no bypass.
- Reading an unwritten or cleared word drives its stored value (0 after reset/clear) with RD_VALID=0.
- No bus arbitration inside the block. Keeping one driver at a time on the shared bus is the system's job.

## Timing
- Write/shift/clear effect is visible in storage after the edge where EN=1 was sampled. It can be read back with OE on the next edge and appears on Q one cycle after that.
- Read latency is exactly 1 cycle: OE/RADDR sampled at edge N, Q driven from edge N until the edge where OE=0 is sampled.
- Back-to-back reads with OE held high and RADDR changing every cycle return one new word per cycle.
- Reset (asynchronous, immediate, independent of clk):
  - all words 0, all valid flags 0;
  - rd_q=0, rv_q=0, oe_q=0, so Q is all-Z and RD_VALID=0;
  - SOUT=0.
- Reset asserted mid-read releases the bus immediately, without waiting for an edge. Reset asserted mid-shift discards the shift.
- After rst deasserts, the first edge operates normally; no dead cycle.
- A simultaneous write and read at different addresses are independent.
- WADDR/RADDR are always in range because DEPTH = 2**ADDR_W.

## Test plan
- Reset then idle: rst=1 → Q=4'bzzzz, RD_VALID=0, SOUT=0. Read all 4 words after release → Q=0000 each, RD_VALID=0.
- Load/read: EN=1 MODE=00 WADDR=2 D=1010, next cycle OE=1 RADDR=2 → one cycle later Q=1010, RD_VALID=1. Drop OE → Q=zzzz the cycle after.
- Shift: load word1=1001, then shift left SIN=1 → word1=0011, SOUT=1. Then shift right SIN=0 → word1=0001, SOUT=1. Read back Q=0001.
- Read-during-write: word0=0101, same edge EN=1 MODE=00 WADDR=0 D=1111 and OE=1 RADDR=0 → Q=0101 next cycle. Re-read → Q=1111.
- Clear: MODE=11 on word3 (previously 0110) → read gives Q=0000, RD_VALID=0. SOUT holds its prior value.
- Async reset mid-read: OE held high with Q=1010 driven, pulse rst between edges → Q goes Z and RD_VALID=0 before the next clk edge. Subsequent read of the word returns 0000.

Source files
------------

// File: rtl/banco_registros_bus.sv
// Register bank of DEPTH x WIDTH words with per-word load, shift left/right and clear, plus one tri-state read port.
// Ports: clk/rst; EN/WADDR/MODE/D/SIN operate on one word per edge, SOUT is the last bit shifted out;
//        OE/RADDR request a read, Q drives the shared bus one cycle later (Z otherwise), RD_VALID flags a written word.
module banco_registros_bus #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [1:0]        MODE,
  input  logic [WIDTH-1:0]  D,
  input  logic              SIN,
  output logic              SOUT,
  input  logic              OE,
  input  logic [ADDR_W-1:0] RADDR,
  output wire  [WIDTH-1:0]  Q,
  output logic              RD_VALID
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    MODE_LOAD  = 2'b00,
    MODE_SHL   = 2'b01,
    MODE_SHR   = 2'b10,
    MODE_CLEAR = 2'b11
  } mode_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic             sout_q;
  logic [WIDTH-1:0] rd_q;
  logic             rv_q;
  logic             oe_q;

  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] word_d;
  logic             vld_d;
  logic             sout_d;

  // Next value of the addressed word; only committed when EN is high.
  always_comb begin
    cur_word = mem_q[WADDR];
    word_d   = cur_word;
    vld_d    = 1'b1;
    sout_d   = sout_q;
    case (mode_e'(MODE))
      MODE_LOAD: begin
        word_d = D;
      end
      MODE_SHL: begin
        word_d = {cur_word[WIDTH-2:0], SIN};
        sout_d = cur_word[WIDTH-1];
      end
      MODE_SHR: begin
        word_d = {SIN, cur_word[WIDTH-1:1]};
        sout_d = cur_word[0];
      end
      MODE_CLEAR: begin
        word_d = '0;
        vld_d  = 1'b0;
      end
      default: begin
        word_d = cur_word;
      end
    endcase
  end

  // Storage, valid flags and serial-out bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q  <= '0;
      sout_q <= 1'b0;
    end else if (EN) begin
      mem_q[WADDR] <= word_d;
      vld_q[WADDR] <= vld_d;
      sout_q       <= sout_d;
    end
  end

  // Read stage samples storage before this edge's write lands, so a
  // same-address read-during-write returns the old word and old flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oe_q <= 1'b0;
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      oe_q <= OE;
      if (OE) begin
        rd_q <= mem_q[RADDR];
        rv_q <= vld_q[RADDR];
      end
    end
  end

  assign SOUT     = sout_q;
  assign Q        = oe_q ? rd_q : {WIDTH{1'bz}};
  assign RD_VALID = oe_q & rv_q;

endmodule
